// File: rtl/mem_arbiter_if.sv
// Cache-fill / write-through bus between the I/D caches, the arbiter and shared memory.
// The master view is the arbiter; the slave view is the caches plus memory.
interface mem_arbiter_if #(
  parameter int unsigned BLK_WORDS = 8,
  parameter int unsigned ADDR_W    = 16
);
  localparam int unsigned CNT_W = $clog2(BLK_WORDS);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [15:0]       d_wr_data;
  logic [15:0]       mem_data_out;
  logic              mem_data_valid;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data_in;
  logic              i_grant;
  logic              d_grant;
  logic              i_data_valid;
  logic              d_data_valid;
  logic [15:0]       fill_data;
  logic [CNT_W-1:0]  fill_word;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_ack;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_out, mem_data_valid,
    output mem_en, mem_wr, mem_addr, mem_data_in, i_grant, d_grant,
    output i_data_valid, d_data_valid, fill_data, fill_word,
    output i_fill_done, d_fill_done, d_wr_ack
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_out, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, mem_data_in, i_grant, d_grant,
    input  i_data_valid, d_data_valid, fill_data, fill_word,
    input  i_fill_done, d_fill_done, d_wr_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache fills, D-cache fills and D-side write-through stores.
// Stores win; fills alternate via last_d; read returns are counted, so memory latency is free.
module mem_arbiter #(
  parameter int unsigned BLK_WORDS = 8,
  parameter int unsigned ADDR_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus
);
  localparam int unsigned       CNT_W     = $clog2(BLK_WORDS);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(BLK_WORDS - 1);
  // Block holds BLK_WORDS 16-bit words, i.e. 2*BLK_WORDS byte addresses.
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * BLK_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StFillI, StFillD} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic              issue_done_q, issue_done_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              fill_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      ret_cnt_q    <= '0;
      last_d_q     <= 1'b0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      issue_done_q <= issue_done_d;
      ret_cnt_q    <= ret_cnt_d;
      last_d_q     <= last_d_d;
      base_q       <= base_d;
    end
  end

  // Pass-through read data is gated so every output is quiet while reset is held.
  assign bus.fill_data = rst_n ? bus.mem_data_out : 16'h0;
  assign bus.fill_word = ret_cnt_q;
  assign fill_i        = (state_q == StFillI);

  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    issue_done_d     = issue_done_q;
    ret_cnt_d        = ret_cnt_q;
    last_d_d         = last_d_q;
    base_d           = base_q;
    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data_in  = 16'h0;
    bus.i_grant      = 1'b0;
    bus.d_grant      = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.d_data_valid = 1'b0;
    bus.i_fill_done  = 1'b0;
    bus.d_fill_done  = 1'b0;
    bus.d_wr_ack     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.d_wr_req) begin
          state_d = StWrite;
        end else if (bus.d_req && !(bus.i_req && last_d_q)) begin
          state_d      = StFillD;
          base_d       = bus.d_addr & BASE_MASK;
          issue_cnt_d  = '0;
          issue_done_d = 1'b0;
          ret_cnt_d    = '0;
        end else if (bus.i_req) begin
          state_d      = StFillI;
          base_d       = bus.i_addr & BASE_MASK;
          issue_cnt_d  = '0;
          issue_done_d = 1'b0;
          ret_cnt_d    = '0;
        end
      end

      StWrite: begin
        bus.mem_en      = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = bus.d_wr_addr;
        bus.mem_data_in = bus.d_wr_data;
        bus.d_wr_ack    = 1'b1;
        state_d         = StIdle;
      end

      StFillI, StFillD: begin
        bus.i_grant = fill_i;
        bus.d_grant = !fill_i;
        if (!issue_done_q) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_q + ADDR_W'({issue_cnt_q, 1'b0});
          issue_cnt_d  = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_WORD) issue_done_d = 1'b1;
        end
        // Completion follows returned words, never the issue count.
        if (bus.mem_data_valid) begin
          bus.i_data_valid = fill_i;
          bus.d_data_valid = !fill_i;
          ret_cnt_d        = ret_cnt_q + 1'b1;
          if (ret_cnt_q == LAST_WORD) begin
            bus.i_fill_done = fill_i;
            bus.d_fill_done = !fill_i;
            last_d_d        = !fill_i;
            state_d         = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-latency memory model, self-dropping cache
// requesters and an event log that each scenario checks against hand-derived cycles.
module tb_mem_arbiter;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   viol = 0;
  logic stray = 1'b0;

  logic [15:0] iss_addr[$];
  int          iss_cyc[$];
  logic [2:0]  i_words[$];
  logic [2:0]  d_words[$];
  logic [15:0] i_data[$];
  logic [15:0] d_data[$];
  int          i_done_cyc[$];
  int          d_done_cyc[$];
  int          wr_cyc[$];
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [31:0] order_word;
  logic        pipe_v[0:LAT];
  logic [15:0] pipe_a[0:LAT];
  logic        prev_ig;
  logic        prev_dg;

  mem_arbiter_if #(.BLK_WORDS(8), .ADDR_W(16)) bus ();

  mem_arbiter #(.BLK_WORDS(8), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.i_grant, bus.d_grant,
             bus.i_data_valid, bus.d_data_valid, bus.fill_data, bus.fill_word,
             bus.i_fill_done, bus.d_fill_done, bus.d_wr_ack};
  endfunction

  function automatic logic [31:0] int_at(input int q[$], input int idx);
    return (idx < q.size()) ? 32'(q[idx]) : 32'hFFFF_FFFF;
  endfunction

  // Memory answers each read LAT cycles after issue; the caches drop a request on its done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) begin
        pipe_v[k] = 1'b0;
        pipe_a[k] = 16'h0;
      end
      bus.mem_data_valid = 1'b0;
      bus.mem_data_out   = 16'h0;
      prev_ig = 1'b0;
      prev_dg = 1'b0;
    end else begin
      for (int k = LAT; k > 0; k--) begin
        pipe_v[k] = pipe_v[k-1];
        pipe_a[k] = pipe_a[k-1];
      end
      pipe_v[0] = bus.mem_en && !bus.mem_wr;
      pipe_a[0] = bus.mem_addr;
      bus.mem_data_valid = pipe_v[LAT] || stray;
      bus.mem_data_out   = stray ? 16'h5A5A : (pipe_v[LAT] ? (pipe_a[LAT] ^ 16'hC3C3) : 16'h0);
      #1;
      if (rst_n) begin
        if (bus.mem_en && !bus.mem_wr) begin
          iss_addr.push_back(bus.mem_addr);
          iss_cyc.push_back(cyc);
        end
        if (bus.mem_wr) begin
          wr_cyc.push_back(cyc);
          wr_addr = bus.mem_addr;
          wr_data = bus.mem_data_in;
          order_word = {order_word[27:0], 4'hA};
          if (!bus.d_wr_ack || !bus.mem_en) viol++;
        end
        if (!bus.mem_wr && bus.mem_data_in != 16'h0) viol++;
        if (bus.d_wr_ack && !bus.mem_wr) viol++;
        if (bus.i_grant && bus.d_grant) viol++;
        if (bus.fill_data != bus.mem_data_out) viol++;
        if (bus.i_grant && !prev_ig) order_word = {order_word[27:0], 4'h1};
        if (bus.d_grant && !prev_dg) order_word = {order_word[27:0], 4'hD};
        prev_ig = bus.i_grant;
        prev_dg = bus.d_grant;
        if (bus.i_data_valid) begin
          if (!bus.i_grant || !bus.mem_data_valid) viol++;
          i_words.push_back(bus.fill_word);
          i_data.push_back(bus.fill_data);
        end
        if (bus.d_data_valid) begin
          if (!bus.d_grant || !bus.mem_data_valid) viol++;
          d_words.push_back(bus.fill_word);
          d_data.push_back(bus.fill_data);
        end
        if (bus.i_fill_done) begin
          if (!bus.i_data_valid) viol++;
          i_done_cyc.push_back(cyc);
          bus.i_req = 1'b0;
        end
        if (bus.d_fill_done) begin
          if (!bus.d_data_valid) viol++;
          d_done_cyc.push_back(cyc);
          bus.d_req = 1'b0;
        end
        if (bus.d_wr_ack) bus.d_wr_req = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    iss_addr.delete();
    iss_cyc.delete();
    i_words.delete();
    d_words.delete();
    i_data.delete();
    d_data.delete();
    i_done_cyc.delete();
    d_done_cyc.delete();
    wr_cyc.delete();
    wr_addr = 16'h0;
    wr_data = 16'h0;
    order_word = 32'h0;
    viol = 0;
  endtask

  task automatic wait_quiet(input string tag);
    int t = 0;
    while ((bus.i_req || bus.d_req || bus.d_wr_req || bus.i_grant || bus.d_grant) && t < 200) begin
      step();
      t++;
    end
    check({tag, "_timeout"}, 32'(t < 200), 32'd1);
    step(2);
  endtask

  task automatic check_burst(input string tag, input logic is_i, input logic [15:0] base,
                             input int off);
    logic [15:0] a;
    logic [31:0] w;
    logic [31:0] d;
    check({tag, "_nwords"}, is_i ? i_words.size() : d_words.size(), 32'd8);
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      if (is_i) begin
        w = (k < i_words.size()) ? 32'(i_words[k]) : 32'hFFFF_FFFF;
        d = (k < i_data.size()) ? 32'(i_data[k]) : 32'hFFFF_FFFF;
      end else begin
        w = (k < d_words.size()) ? 32'(d_words[k]) : 32'hFFFF_FFFF;
        d = (k < d_data.size()) ? 32'(d_data[k]) : 32'hFFFF_FFFF;
      end
      check($sformatf("%s_addr%0d", tag, k),
            (off + k < iss_addr.size()) ? 32'(iss_addr[off+k]) : 32'hFFFF_FFFF, 32'(a));
      check($sformatf("%s_word%0d", tag, k), w, 32'(k));
      check($sformatf("%s_data%0d", tag, k), d, 32'(a ^ 16'hC3C3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    bus.i_req = 1'b0;
    bus.i_addr = 16'h0;
    bus.d_req = 1'b0;
    bus.d_addr = 16'h0;
    bus.d_wr_req = 1'b0;
    bus.d_wr_addr = 16'h0;
    bus.d_wr_data = 16'h0;
    bus.mem_data_out = 16'h0;
    bus.mem_data_valid = 1'b0;
    clear_logs();

    step(2);
    check("rst_outs", 32'(any_out()), 32'd0);
    rst_n = 1'b1;
    step(2);
    check("idle_outs", 32'(any_out()), 32'd0);

    // Single I fill, latency 4.
    clear_logs();
    bus.i_addr = 16'h0046;
    bus.i_req = 1'b1;
    n = cyc;
    wait_quiet("t2");
    check("t2_first_issue", int_at(iss_cyc, 0), 32'(n + 1));
    check("t2_last_issue", int_at(iss_cyc, 7), 32'(n + 8));
    check("t2_nissue", iss_cyc.size(), 32'd8);
    check_burst("t2", 1'b1, 16'h0040, 0);
    check("t2_done", int_at(i_done_cyc, 0), 32'(n + 12));
    check("t2_ndone", i_done_cyc.size(), 32'd1);
    check("t2_proto", viol, 32'd0);

    // Simultaneous D and I straight out of reset: D first.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    clear_logs();
    bus.d_addr = 16'h201A;
    bus.i_addr = 16'h0100;
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    n = cyc;
    wait_quiet("t3");
    check("t3_order", order_word, 32'h0000_00D1);
    check_burst("t3_d", 1'b0, 16'h2010, 0);
    check_burst("t3_i", 1'b1, 16'h0100, 8);
    check("t3_d_done", int_at(d_done_cyc, 0), 32'(n + 12));
    check("t3_i_start", int_at(iss_cyc, 8), 32'(n + 14));
    check("t3_i_done", int_at(i_done_cyc, 0), 32'(n + 25));
    check("t3_proto", viol, 32'd0);

    // Store arriving mid-fill waits for the fill.
    clear_logs();
    bus.i_addr = 16'h0202;
    bus.i_req = 1'b1;
    n = cyc;
    step(3);
    bus.d_wr_addr = 16'h1234;
    bus.d_wr_data = 16'hBEEF;
    bus.d_wr_req = 1'b1;
    wait_quiet("t4");
    check("t4_i_done", int_at(i_done_cyc, 0), 32'(n + 12));
    check("t4_nwr", wr_cyc.size(), 32'd1);
    check("t4_wr_cyc", int_at(wr_cyc, 0), 32'(n + 14));
    check("t4_wr_addr", 32'(wr_addr), 32'h1234);
    check("t4_wr_data", 32'(wr_data), 32'hBEEF);
    check("t4_order", order_word, 32'h0000_001A);
    check("t4_proto", viol, 32'd0);

    // All three together, then D alone, then D+I with last_d set.
    clear_logs();
    bus.d_wr_addr = 16'h0ABC;
    bus.d_wr_data = 16'h1111;
    bus.d_addr = 16'h4000;
    bus.i_addr = 16'h5000;
    bus.d_wr_req = 1'b1;
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    n = cyc;
    wait_quiet("t5a");
    check("t5_wr_cyc", int_at(wr_cyc, 0), 32'(n + 1));
    check("t5_d_start", int_at(iss_cyc, 0), 32'(n + 3));
    bus.d_req = 1'b1;
    wait_quiet("t5b");
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    wait_quiet("t5c");
    check("t5_order", order_word, 32'h00AD_1D1D);
    check("t5_ndone_d", d_done_cyc.size(), 32'd3);
    check("t5_ndone_i", i_done_cyc.size(), 32'd2);
    check("t5_proto", viol, 32'd0);

    // Reset on the 3rd returned D word; held request restarts cleanly.
    clear_logs();
    bus.d_addr = 16'h3000;
    bus.d_req = 1'b1;
    n = cyc;
    t = 0;
    while (d_words.size() < 3 && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("t6_third_cyc", 32'(cyc), 32'(n + 7));
    rst_n = 1'b0;
    #1;
    check("t6_async_outs", 32'(any_out()), 32'd0);
    step(2);
    check("t6_hold_outs", 32'(any_out()), 32'd0);
    check("t6_no_done", d_done_cyc.size(), 32'd0);
    clear_logs();
    rst_n = 1'b1;
    n = cyc;
    wait_quiet("t6");
    check("t6_restart_issue", int_at(iss_cyc, 0), 32'(n + 1));
    check_burst("t6", 1'b0, 16'h3000, 0);
    check("t6_ndone", d_done_cyc.size(), 32'd1);

    // Stray read data in IDLE is ignored.
    clear_logs();
    step();
    stray = 1'b1;
    @(negedge clk);
    #2;
    check("t7_i_valid", 32'(bus.i_data_valid), 32'd0);
    check("t7_d_valid", 32'(bus.d_data_valid), 32'd0);
    check("t7_fill_data", 32'(bus.fill_data), 32'h5A5A);
    check("t7_fill_word", 32'(bus.fill_word), 32'd0);
    step();
    stray = 1'b0;
    step();
    bus.i_addr = 16'h00F8;
    bus.i_req = 1'b1;
    wait_quiet("t7");
    check_burst("t7", 1'b1, 16'h00F0, 0);
    check("t7_ndone", i_done_cyc.size(), 32'd1);
    check("t7_proto", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
